// File: rtl/alu_pkg.sv
// Shared opcode encodings and handshake FSM states for the multi-cycle ALU.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_SLT = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_AND = 4'h4;
  localparam logic [3:0] OP_SHL = 4'h5;
  localparam logic [3:0] OP_SHR = 4'h6;
  localparam logic [3:0] OP_SRA = 4'h7;
  localparam logic [3:0] OP_MUL = 4'h8;
  localparam logic [3:0] OP_EQ  = 4'h9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one partial product per clock, WIDTH clocks per product.
module alu_mul_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] addend;
  logic [CW-1:0]    cnt;
  logic             busy_q;

  always_comb begin
    addend = '0;
    if (b_q[cnt]) addend = a_q << cnt;
  end

  // product includes the current step, so it is final on the edge where done is high
  assign product = acc + addend;
  assign done    = busy_q && (cnt == CW'(WIDTH - 1));
  assign busy    = busy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      acc    <= '0;
      cnt    <= '0;
      busy_q <= 1'b0;
    end else if (start) begin
      a_q    <= a;
      b_q    <= b;
      acc    <= '0;
      cnt    <= '0;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      acc <= product;
      cnt <= cnt + 1'b1;
      if (done) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with registered result, status flags and valid/ready on both sides.
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int SLT_SIGNED = 0,
  parameter int MUL_EN     = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic             zero,
  output logic             carry,
  output logic             ovf,
  output logic             err
);

  localparam int SW = $clog2(WIDTH);

  state_t state, state_n;

  logic             take;
  logic             is_mul;
  logic             load_alu;
  logic             mul_start;
  logic             mul_busy;
  logic             mul_done;
  logic [WIDTH-1:0] mul_prod;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [SW-1:0]    sh;
  logic             big;
  logic             lt;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_v;
  logic             alu_e;

  logic [WIDTH-1:0] res_q;
  logic             zero_q, carry_q, ovf_q, err_q;

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .a       (a),
    .b       (b),
    .start   (mul_start),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_prod)
  );

  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};
  assign sh   = b[SW-1:0];
  assign big  = (b >= WIDTH'(WIDTH));
  assign lt   = (SLT_SIGNED != 0) ? ($signed(a) < $signed(b)) : (a < b);

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_e   = 1'b0;
    case (op)
      OP_ADD: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff[WIDTH-1:0];
        alu_c   = diff[WIDTH];
        alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, lt};
      OP_OR:   alu_res = a | b;
      OP_AND:  alu_res = a & b;
      OP_SHL:  alu_res = big ? '0 : (a << sh);
      OP_SHR:  alu_res = big ? '0 : (a >> sh);
      OP_SRA:  alu_res = big ? {WIDTH{a[WIDTH-1]}} : WIDTH'($signed(a) >>> sh);
      OP_EQ:   alu_res = {{(WIDTH-1){1'b0}}, (a == b)};
      default: begin
        alu_res = '1;
        alu_e   = 1'b1;
      end
    endcase
  end

  assign is_mul   = (MUL_EN != 0) && (op == OP_MUL);
  assign in_ready = !mul_busy && ((state == ST_IDLE) || ((state == ST_DONE) && out_ready));
  assign take     = in_valid && in_ready;

  always_comb begin
    state_n   = state;
    load_alu  = 1'b0;
    mul_start = 1'b0;
    if (take) begin
      if (is_mul) begin
        mul_start = 1'b1;
        state_n   = ST_MUL;
      end else begin
        load_alu = 1'b1;
        state_n  = ST_DONE;
      end
    end else begin
      case (state)
        ST_MUL:  if (mul_done) state_n = ST_DONE;
        ST_DONE: if (out_ready) state_n = ST_IDLE;
        default: state_n = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      res_q   <= '0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state <= state_n;
      if (load_alu) begin
        res_q   <= alu_res;
        zero_q  <= (alu_res == '0);
        carry_q <= alu_c;
        ovf_q   <= alu_v;
        err_q   <= alu_e;
      end else if ((state == ST_MUL) && mul_done) begin
        res_q   <= mul_prod;
        zero_q  <= (mul_prod == '0);
        carry_q <= 1'b0;
        ovf_q   <= 1'b0;
        err_q   <= 1'b0;
      end
    end
  end

  assign out_valid = (state == ST_DONE);
  assign res       = res_q;
  assign zero      = zero_q;
  assign carry     = carry_q;
  assign ovf       = ovf_q;
  assign err       = err_q;

endmodule

// File: tb/tb_alu_mc.sv
// Table-driven, directed and randomized scoreboard bench for alu_mc (WIDTH=16).
module tb_alu_mc;
  import alu_pkg::*;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [3:0]   op = 4'h0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         in_ready, out_valid, zero, carry, ovf, err;
  logic [W-1:0] res;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic        z;
    logic        c;
    logic        v;
    logic        e;
  } vec_t;

  vec_t tbl[18];
  vec_t sbq[$];

  always #5 clk = ~clk;

  alu_mc #(.WIDTH(W), .SLT_SIGNED(0), .MUL_EN(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res       (res),
    .zero      (zero),
    .carry     (carry),
    .ovf       (ovf),
    .err       (err)
  );

  function automatic vec_t mk(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y,
                              input logic [15:0] r, input logic z, input logic c,
                              input logic v, input logic e);
    vec_t t;
    t.op = o; t.a = x; t.b = y; t.res = r; t.z = z; t.c = c; t.v = v; t.e = e;
    return t;
  endfunction

  // Reference computed from the opcode definitions with plain integer arithmetic
  function automatic vec_t model(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y);
    vec_t   r;
    int     ux, uy, sx, sy, t;
    longint p;
    ux = int'({16'h0, x});
    uy = int'({16'h0, y});
    sx = int'($signed(x));
    sy = int'($signed(y));
    r.op = o; r.a = x; r.b = y; r.c = 1'b0; r.v = 1'b0; r.e = 1'b0; r.res = 16'h0;
    case (o)
      OP_ADD: begin
        t = ux + uy; r.res = t[15:0]; r.c = (t > 65535);
        r.v = ((sx + sy) > 32767) || ((sx + sy) < -32768);
      end
      OP_SUB: begin
        t = ux - uy; r.res = t[15:0]; r.c = (ux < uy);
        r.v = ((sx - sy) > 32767) || ((sx - sy) < -32768);
      end
      OP_SLT: r.res = (ux < uy) ? 16'd1 : 16'd0;
      OP_OR:  r.res = x | y;
      OP_AND: r.res = x & y;
      OP_SHL: begin t = ux << uy; r.res = (uy >= 16) ? 16'h0 : t[15:0]; end
      OP_SHR: begin t = ux >> uy; r.res = (uy >= 16) ? 16'h0 : t[15:0]; end
      OP_SRA: begin
        t = sx >>> uy;
        r.res = (uy >= 16) ? ((sx < 0) ? 16'hFFFF : 16'h0) : t[15:0];
      end
      OP_MUL: begin p = longint'(ux) * longint'(uy); r.res = p[15:0]; end
      OP_EQ:  r.res = (ux == uy) ? 16'd1 : 16'd0;
      default: begin r.res = 16'hFFFF; r.e = 1'b1; end
    endcase
    r.z = (r.res == 16'h0);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string nm, input vec_t e);
    n_cmp++;
    if ({out_valid, res, zero, carry, ovf, err} !== {1'b1, e.res, e.z, e.c, e.v, e.e}) begin
      n_bad++;
      $display("FAIL %s: got v=%0b res=%h z=%0b c=%0b o=%0b e=%0b expected v=1 res=%h z=%0b c=%0b o=%0b e=%0b",
               nm, out_valid, res, zero, carry, ovf, err, e.res, e.z, e.c, e.v, e.e);
    end
  endtask

  task automatic timeout(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timeout", nm);
  endtask

  // Issue one op with out_ready=1 and check the returned result against the given expectation
  task automatic run_vec(input string nm, input vec_t v);
    int k;
    @(negedge clk);
    in_valid = 1'b1; op = v.op; a = v.a; b = v.b; out_ready = 1'b1;
    #1;
    k = 0;
    while (!in_ready && k < 40) begin @(negedge clk); #1; k++; end
    if (!in_ready) timeout({nm, " accept"});
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    k = 0;
    while (!out_valid && k < 40) begin @(negedge clk); #1; k++; end
    if (!out_valid) timeout({nm, " result"});
    else chk_out(nm, v);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int hi;
    vec_t e;

    tbl[0]  = mk(OP_ADD, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0);
    tbl[1]  = mk(OP_SUB, 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b0, 1'b1, 1'b0);
    tbl[2]  = mk(OP_SUB, 16'h0003, 16'h0005, 16'hFFFE, 1'b0, 1'b1, 1'b0, 1'b0);
    tbl[3]  = mk(OP_SHL, 16'h0001, 16'h0010, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
    tbl[4]  = mk(OP_SRA, 16'h8000, 16'h0004, 16'hF800, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[5]  = mk(OP_SHR, 16'h8000, 16'h0004, 16'h0800, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[6]  = mk(4'hF,   16'h1234, 16'h5678, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1);
    tbl[7]  = mk(OP_SLT, 16'h0003, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[8]  = mk(OP_SLT, 16'hFFFF, 16'h0003, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
    tbl[9]  = mk(OP_OR,  16'h0F0F, 16'hF000, 16'hFF0F, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[10] = mk(OP_AND, 16'h0F0F, 16'h00FF, 16'h000F, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[11] = mk(OP_EQ,  16'h1234, 16'h1234, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[12] = mk(OP_EQ,  16'h1234, 16'h1235, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
    tbl[13] = mk(OP_SRA, 16'h8000, 16'h0020, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[14] = mk(OP_SHR, 16'h8001, 16'h000F, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[15] = mk(OP_MUL, 16'h00FF, 16'h0101, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[16] = mk(OP_ADD, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b0, 1'b1, 1'b0);
    tbl[17] = mk(OP_MUL, 16'h0000, 16'h0005, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);

    // Reset state
    #2;
    chk("in_ready in reset", {31'h0, in_ready}, 32'h1);
    chk("out_valid in reset", {31'h0, out_valid}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("res after reset", {16'h0, res}, 32'h0);
    chk("flags after reset", {28'h0, zero, carry, ovf, err}, 32'h0);

    for (int i = 0; i < 18; i++) run_vec($sformatf("vec%0d", i), tbl[i]);

    // MUL latency, with a second request held during the wait
    @(negedge clk);
    in_valid = 1'b1; op = OP_MUL; a = 16'h00FF; b = 16'h0101; out_ready = 1'b1;
    #1;
    chk("mul accept ready", {31'h0, in_ready}, 32'h1);
    @(negedge clk);
    op = OP_ADD; a = 16'h0002; b = 16'h0003;
    #1;
    k = 0;
    while (!in_ready && k < 40) begin k++; @(negedge clk); #1; end
    chk("mul busy cycles", k, 32'd16);
    chk_out("mul result", model(OP_MUL, 16'h00FF, 16'h0101));
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk_out("held add after mul", model(OP_ADD, 16'h0002, 16'h0003));

    // Backpressure: result held stable, in_ready follows out_ready
    @(negedge clk);
    in_valid = 1'b1; op = OP_SUB; a = 16'h0003; b = 16'h0005; out_ready = 1'b0;
    @(negedge clk);
    op = OP_ADD; a = 16'h0002; b = 16'h0003;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk_out($sformatf("stall%0d", i), model(OP_SUB, 16'h0003, 16'h0005));
      chk($sformatf("stall%0d in_ready", i), {31'h0, in_ready}, 32'h0);
      @(negedge clk); #1;
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    chk("release in_ready", {31'h0, in_ready}, 32'h1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk_out("back-to-back add", model(OP_ADD, 16'h0002, 16'h0003));
    @(negedge clk); #1;
    chk("out_valid drops", {31'h0, out_valid}, 32'h0);

    // Asynchronous reset in the middle of a multiply
    @(negedge clk);
    in_valid = 1'b1; op = OP_MUL; a = 16'h0003; b = 16'h0007;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (6) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("reset mid-mul out_valid", {31'h0, out_valid}, 32'h0);
    chk("reset mid-mul res", {16'h0, res}, 32'h0);
    chk("reset mid-mul in_ready", {31'h0, in_ready}, 32'h1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_vec("add after reset", model(OP_ADD, 16'h0001, 16'h0001));
    hi = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk); #1;
      if (out_valid) hi++;
    end
    chk("no stale product", hi, 32'd0);

    // Randomized traffic against a scoreboard queue
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      in_valid  = ($urandom_range(0, 2) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      op        = 4'($urandom_range(0, 15));
      a         = 16'($urandom);
      b         = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 20)) : 16'($urandom);
      #1;
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) timeout("unexpected output");
        else begin
          e = sbq.pop_front();
          chk_out($sformatf("rand op=%h a=%h b=%h", e.op, e.a, e.b), e);
        end
      end
      if (in_valid && in_ready) sbq.push_back(model(op, a, b));
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      #1;
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) timeout("unexpected drain output");
        else begin
          e = sbq.pop_front();
          chk_out($sformatf("drain op=%h a=%h b=%h", e.op, e.a, e.b), e);
        end
      end
      @(negedge clk);
    end
    chk("scoreboard empty", sbq.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
